// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle IF/ID/EX/MEM/WB sequencer for the MIPS datapath.
// Instruction fetch and data access use req/rdy handshakes guarded by a wait-cycle timeout.
module mc_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ins,
   input  logic        zero,
   input  logic        imRdy,
   input  logic        dmRdy,
   output logic        imReq,
   output logic        dmReq,
   output logic        irWr,
   output logic        pcWr,
   output logic [1:0]  pcSrc,
   output logic        regWr,
   output logic        regDst,
   output logic        aluSrc,
   output logic        extOp,
   output logic        memtoReg,
   output logic        memWr,
   output logic [3:0]  aluCtr,
   output logic        illegal,
   output logic        trap,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_ERR = 3'd7;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_LUI = 4'b0101;

   localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 32'd1);

   function automatic logic [3:0] r_alu(input logic [5:0] fn);
      logic [3:0] a;
      case (fn)
         FN_ADDU: a = ALU_ADD;
         FN_SUBU: a = ALU_SUB;
         FN_AND:  a = ALU_AND;
         FN_OR:   a = ALU_OR;
         FN_SLT:  a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   logic [2:0] state_r;
   logic [2:0] nxt_s;
   logic       trap_r;
   logic [9:0] cnt_r;
   logic [5:0] op_s;
   logic [5:0] fn_s;
   logic       is_r_s, is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, legal_s;
   logic       wait_s;
   logic       timeout_s;
   logic       unused_ins_s;

   assign op_s         = ins[31:26];
   assign fn_s         = ins[5:0];
   assign unused_ins_s = ^ins[25:6];
   assign trap         = trap_r;
   assign state        = state_r;

   // Instruction class decode from the IR contents
   always_comb begin
      is_r_s   = 1'b0;
      is_ori_s = 1'b0;
      is_lui_s = 1'b0;
      is_lw_s  = 1'b0;
      is_sw_s  = 1'b0;
      is_beq_s = 1'b0;
      is_j_s   = 1'b0;
      case (op_s)
         OP_R: begin
            case (fn_s)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: is_r_s = 1'b1;
               default:                                 is_r_s = 1'b0;
            endcase
         end
         OP_ORI:  is_ori_s = 1'b1;
         OP_LUI:  is_lui_s = 1'b1;
         OP_LW:   is_lw_s  = 1'b1;
         OP_SW:   is_sw_s  = 1'b1;
         OP_BEQ:  is_beq_s = 1'b1;
         OP_J:    is_j_s   = 1'b1;
         default: is_r_s   = 1'b0;
      endcase
      legal_s = is_r_s | is_ori_s | is_lui_s | is_lw_s | is_sw_s | is_beq_s | is_j_s;
   end

   // Handshake wait detection; rdy in the last allowed cycle still wins over the timeout
   always_comb begin
      if (state_r == S_IF) begin
         wait_s = ~imRdy;
      end else if (state_r == S_MEM) begin
         wait_s = ~dmRdy;
      end else begin
         wait_s = 1'b0;
      end
      timeout_s = wait_s & (cnt_r == WAIT_LAST);
   end

   // Next-state selection
   always_comb begin
      nxt_s = state_r;
      case (state_r)
         S_IF: begin
            if (imRdy) begin
               nxt_s = S_ID;
            end else if (timeout_s) begin
               nxt_s = S_ERR;
            end else begin
               nxt_s = S_IF;
            end
         end
         S_ID: begin
            if (!legal_s || is_j_s) begin
               nxt_s = S_IF;
            end else begin
               nxt_s = S_EX;
            end
         end
         S_EX: begin
            if (is_lw_s || is_sw_s) begin
               nxt_s = S_MEM;
            end else if (is_beq_s) begin
               nxt_s = S_IF;
            end else begin
               nxt_s = S_WB;
            end
         end
         S_MEM: begin
            if (dmRdy) begin
               nxt_s = is_sw_s ? S_IF : S_WB;
            end else if (timeout_s) begin
               nxt_s = S_ERR;
            end else begin
               nxt_s = S_MEM;
            end
         end
         S_WB:    nxt_s = S_IF;
         S_ERR:   nxt_s = S_ERR;
         default: nxt_s = S_ERR;
      endcase
   end

   // State, sticky trap and wait counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IF;
         trap_r  <= 1'b0;
         cnt_r   <= 10'd0;
      end else begin
         state_r <= nxt_s;
         trap_r  <= trap_r | (nxt_s == S_ERR);
         if (nxt_s != state_r) begin
            cnt_r <= 10'd0;
         end else if (wait_s) begin
            cnt_r <= cnt_r + 10'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Per-state strobes; ALU controls stay valid from EX through WB so the
   // address and writeback paths remain stable while the access completes
   always_comb begin
      imReq    = 1'b0;
      dmReq    = 1'b0;
      irWr     = 1'b0;
      pcWr     = 1'b0;
      pcSrc    = 2'b00;
      regWr    = 1'b0;
      regDst   = 1'b0;
      aluSrc   = 1'b0;
      extOp    = 1'b0;
      memtoReg = 1'b0;
      memWr    = 1'b0;
      aluCtr   = ALU_ADD;
      illegal  = 1'b0;
      if (rst) begin
         illegal = 1'b0;
      end else begin
         case (state_r)
            S_IF: begin
               imReq = 1'b1;
               irWr  = imRdy;
               pcWr  = imRdy;
            end
            S_ID: begin
               if (!legal_s) begin
                  illegal = 1'b1;
               end else if (is_j_s) begin
                  pcWr  = 1'b1;
                  pcSrc = 2'b10;
               end else begin
                  illegal = 1'b0;
               end
            end
            S_EX: begin
               if (is_beq_s) begin
                  pcWr  = zero;
                  pcSrc = 2'b01;
               end else begin
                  pcWr = 1'b0;
               end
            end
            S_MEM: begin
               dmReq = 1'b1;
               memWr = is_sw_s;
            end
            S_WB: begin
               regWr    = 1'b1;
               regDst   = is_r_s;
               memtoReg = is_lw_s;
            end
            S_ERR:   illegal = 1'b0;
            default: illegal = 1'b0;
         endcase
         if ((state_r == S_EX) || (state_r == S_MEM) || (state_r == S_WB)) begin
            if (is_r_s) begin
               aluCtr = r_alu(fn_s);
            end else if (is_ori_s) begin
               aluSrc = 1'b1;
               aluCtr = ALU_OR;
            end else if (is_lui_s) begin
               aluSrc = 1'b1;
               aluCtr = ALU_LUI;
            end else if (is_lw_s || is_sw_s) begin
               aluSrc = 1'b1;
               extOp  = 1'b1;
               aluCtr = ALU_ADD;
            end else if (is_beq_s) begin
               aluCtr = ALU_SUB;
            end else begin
               aluCtr = ALU_ADD;
            end
         end else begin
            aluCtr = ALU_ADD;
         end
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: trace-based checker for mc_ctrl. Each instruction is expanded into the
// cycle-by-cycle output sequence the sequencer must produce, then replayed and compared.
module tb_mc_ctrl;

   localparam int TMO = 4;
   localparam int K_ILL = 0, K_R = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5, K_BEQ = 6, K_J = 7;

   typedef struct {
      logic        rst, im_rdy, dm_rdy, zero;
      logic [31:0] ins;
      logic [2:0]  st;
      logic        chk_st;
      logic        im_req, dm_req, ir_wr, pc_wr, reg_wr, mem_wr, ill;
      logic        trap, chk_trap;
      logic [1:0]  pc_src;
      logic        chk_pcsrc;
      logic [3:0]  alu;
      logic        chk_alu;
      logic        alu_src, chk_src, ext, chk_ext;
      logic        reg_dst, mem_to_reg, chk_wb;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst, zero, imRdy, dmRdy;
   logic [31:0] ins;
   logic        imReq, dmReq, irWr, pcWr, regWr, regDst, aluSrc, extOp, memtoReg, memWr;
   logic        illegal, trap;
   logic [1:0]  pcSrc;
   logic [3:0]  aluCtr;
   logic [2:0]  state;

   int   n_tests = 0;
   int   n_fail  = 0;
   rec_t q[$];
   rec_t tr[$];
   rec_t cur;
   bit   cur_valid = 1'b0;

   always #5 clk = ~clk;

   mc_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ins(ins), .zero(zero), .imRdy(imRdy), .dmRdy(dmRdy),
      .imReq(imReq), .dmReq(dmReq), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
      .regWr(regWr), .regDst(regDst), .aluSrc(aluSrc), .extOp(extOp),
      .memtoReg(memtoReg), .memWr(memWr), .aluCtr(aluCtr), .illegal(illegal),
      .trap(trap), .state(state)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int kind(input logic [31:0] iw);
      logic [5:0] op, fn;
      op = iw[31:26];
      fn = iw[5:0];
      case (op)
         6'h00:   return (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? K_R : K_ILL;
         6'h0D:   return K_ORI;
         6'h0F:   return K_LUI;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h02:   return K_J;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] exp_alu(input logic [31:0] iw);
      logic [5:0] fn;
      fn = iw[5:0];
      case (kind(iw))
         K_R: begin
            case (fn)
               6'h23:   return 4'b0001;
               6'h24:   return 4'b0011;
               6'h25:   return 4'b0010;
               6'h2A:   return 4'b0100;
               default: return 4'b0000;
            endcase
         end
         K_ORI:   return 4'b0010;
         K_LUI:   return 4'b0101;
         K_BEQ:   return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic rec_t blank(input logic [2:0] st, input logic [31:0] iw);
      rec_t r;
      r = '{default: '0};
      r.im_rdy   = 1'($urandom);
      r.dm_rdy   = 1'($urandom);
      r.zero     = 1'($urandom);
      r.ins      = iw;
      r.st       = st;
      r.chk_st   = 1'b1;
      r.chk_trap = 1'b1;
      return r;
   endfunction

   function automatic rec_t make_rst(input rec_t base);
      rec_t r;
      r = base;
      r.rst = 1'b1;
      r.im_req = 1'b0; r.dm_req = 1'b0; r.ir_wr = 1'b0; r.pc_wr = 1'b0;
      r.reg_wr = 1'b0; r.mem_wr = 1'b0; r.ill = 1'b0;
      r.chk_pcsrc = 1'b1; r.pc_src = 2'b00;
      r.chk_alu = 1'b1; r.alu = 4'b0000;
      r.chk_src = 1'b0; r.chk_ext = 1'b0; r.chk_wb = 1'b0;
      return r;
   endfunction

   task automatic add_err();
      rec_t r;
      for (int i = 0; i < 3; i++) begin
         r = blank(3'd7, $urandom);
         r.trap = 1'b1;
         tr.push_back(r);
      end
   endtask

   // Expected cycle trace of one instruction: di/dd = not-ready cycles before imRdy/dmRdy
   task automatic build(input logic [31:0] iw, input int di, input int dd, input logic z, output bit err);
      rec_t r;
      int   k;
      err = 1'b0;
      for (int c = 0; c < di && c < TMO; c++) begin
         r = blank(3'd0, $urandom);
         r.im_rdy = 1'b0; r.im_req = 1'b1;
         tr.push_back(r);
      end
      if (di >= TMO) begin
         add_err();
         err = 1'b1;
         return;
      end
      r = blank(3'd0, $urandom);
      r.im_rdy = 1'b1; r.im_req = 1'b1; r.ir_wr = 1'b1; r.pc_wr = 1'b1; r.chk_pcsrc = 1'b1;
      tr.push_back(r);
      k = kind(iw);
      r = blank(3'd1, iw);
      if (k == K_ILL) begin
         r.ill = 1'b1;
         tr.push_back(r);
         return;
      end
      if (k == K_J) begin
         r.pc_wr = 1'b1; r.pc_src = 2'b10; r.chk_pcsrc = 1'b1;
         tr.push_back(r);
         return;
      end
      tr.push_back(r);
      r = blank(3'd2, iw);
      r.chk_alu = 1'b1; r.alu = exp_alu(iw);
      if (k == K_R || k == K_BEQ) begin r.chk_src = 1'b1; r.alu_src = 1'b0; end
      if (k == K_ORI) begin r.chk_src = 1'b1; r.alu_src = 1'b1; r.chk_ext = 1'b1; r.ext = 1'b0; end
      if (k == K_LW || k == K_SW) begin r.chk_src = 1'b1; r.alu_src = 1'b1; r.chk_ext = 1'b1; r.ext = 1'b1; end
      if (k == K_BEQ) begin
         r.zero = z; r.pc_wr = z; r.pc_src = 2'b01; r.chk_pcsrc = 1'b1;
         tr.push_back(r);
         return;
      end
      tr.push_back(r);
      if (k == K_LW || k == K_SW) begin
         for (int c = 0; c <= dd && c < TMO; c++) begin
            r = blank(3'd3, iw);
            r.dm_rdy = (c == dd); r.dm_req = 1'b1; r.mem_wr = (k == K_SW);
            tr.push_back(r);
         end
         if (dd >= TMO) begin
            add_err();
            err = 1'b1;
            return;
         end
         if (k == K_SW) return;
      end
      r = blank(3'd4, iw);
      r.reg_wr = 1'b1; r.chk_wb = 1'b1; r.reg_dst = (k == K_R); r.mem_to_reg = (k == K_LW);
      tr.push_back(r);
   endtask

   // cut > 0 replaces trace cycle 'cut' with a reset cycle and abandons the rest
   task automatic run_txn(input logic [31:0] iw, input int di, input int dd, input logic z, input int cut);
      bit   err;
      rec_t r;
      tr.delete();
      build(iw, di, dd, z, err);
      if (cut > 0 && cut < tr.size()) begin
         r = tr[cut];
         while (tr.size() > cut) void'(tr.pop_back());
         foreach (tr[i]) q.push_back(tr[i]);
         q.push_back(make_rst(r));
      end else begin
         foreach (tr[i]) q.push_back(tr[i]);
         if (err) q.push_back(make_rst(tr[tr.size()-1]));
      end
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0, 1: begin
            w[31:26] = 6'h00;
            case ($urandom_range(0, 5))
               0: w[5:0] = 6'h21;
               1: w[5:0] = 6'h23;
               2: w[5:0] = 6'h24;
               3: w[5:0] = 6'h25;
               4: w[5:0] = 6'h2A;
               default: w[5:0] = w[5:0];
            endcase
         end
         2: w[31:26] = 6'h0D;
         3: w[31:26] = 6'h23;
         4: w[31:26] = 6'h2B;
         5: w[31:26] = 6'h04;
         6: w[31:26] = 6'h02;
         7: w[31:26] = 6'h0F;
         default: w[31:26] = w[31:26];
      endcase
      return w;
   endfunction

   function automatic int rand_delay();
      int s;
      s = $urandom_range(0, 9);
      if (s <= 5) return 0;
      if (s <= 7) return $urandom_range(1, 2);
      if (s == 8) return TMO - 1;
      return ($urandom_range(0, 3) == 0) ? TMO : 0;
   endfunction

   // Compare process: DUT outputs against the expected trace, mid-cycle
   always @(negedge clk) begin
      if (cur_valid) begin
         chk("imReq", int'(imReq), int'(cur.im_req));
         chk("dmReq", int'(dmReq), int'(cur.dm_req));
         chk("irWr", int'(irWr), int'(cur.ir_wr));
         chk("pcWr", int'(pcWr), int'(cur.pc_wr));
         chk("regWr", int'(regWr), int'(cur.reg_wr));
         chk("memWr", int'(memWr), int'(cur.mem_wr));
         chk("illegal", int'(illegal), int'(cur.ill));
         if (cur.chk_st)    chk("state", int'(state), int'(cur.st));
         if (cur.chk_trap)  chk("trap", int'(trap), int'(cur.trap));
         if (cur.chk_pcsrc) chk("pcSrc", int'(pcSrc), int'(cur.pc_src));
         if (cur.chk_alu)   chk("aluCtr", int'(aluCtr), int'(cur.alu));
         if (cur.chk_src)   chk("aluSrc", int'(aluSrc), int'(cur.alu_src));
         if (cur.chk_ext)   chk("extOp", int'(extOp), int'(cur.ext));
         if (cur.chk_wb) begin
            chk("regDst", int'(regDst), int'(cur.reg_dst));
            chk("memtoReg", int'(memtoReg), int'(cur.mem_to_reg));
         end
      end
   end

   initial begin
      bit   err;
      int   cnt;
      rec_t r;
      rst = 1'b1; zero = 1'b0; imRdy = 1'b0; dmRdy = 1'b0; ins = 32'd0;

      // Hand-derived trace shapes pin the model
      tr.delete(); build(32'h00221821, 0, 0, 1'b0, err);
      chk("pin_addu_len", tr.size(), 4);
      chk("pin_addu_wb_state", int'(tr[3].st), 4);
      chk("pin_addu_regdst", int'(tr[3].reg_dst), 1);
      tr.delete(); build(32'h8C220004, 0, 3, 1'b0, err);
      cnt = 0;
      foreach (tr[i]) if (tr[i].dm_req) cnt++;
      chk("pin_lw_len", tr.size(), 8);
      chk("pin_lw_dmreq_cycles", cnt, 4);
      tr.delete(); build(32'hAC220008, 0, 0, 1'b0, err);
      chk("pin_sw_len", tr.size(), 4);
      tr.delete(); build(32'h10220003, 0, 0, 1'b1, err);
      chk("pin_beq_len", tr.size(), 3);
      tr.delete(); build(32'h08000010, 0, 0, 1'b0, err);
      chk("pin_j_len", tr.size(), 2);
      tr.delete(); build(32'hFC000000, 0, 0, 1'b0, err);
      chk("pin_ill_pulse", int'(tr[1].ill), 1);
      tr.delete(); build(32'h00221821, 4, 0, 1'b0, err);
      chk("pin_timeout_err", int'(err), 1);
      chk("pin_timeout_state", int'(tr[4].st), 7);

      r = blank(3'd0, 32'd0);
      r.chk_st = 1'b0; r.chk_trap = 1'b0;
      q.push_back(make_rst(r));
      q.push_back(make_rst(r));

      run_txn(32'h00221821, 0, 0, 1'b0, 0);   // addu
      run_txn(32'h8C220004, 0, 3, 1'b0, 0);   // lw, slow DM
      run_txn(32'h10220003, 0, 0, 1'b1, 0);   // beq taken
      run_txn(32'h10220003, 1, 0, 1'b0, 0);   // beq not taken
      run_txn(32'hFC000000, 0, 0, 1'b0, 0);   // illegal opcode
      run_txn(32'h00221821, TMO, 0, 1'b0, 0); // IM timeout
      run_txn(32'h00221821, TMO-1, 0, 1'b0, 0);
      run_txn(32'hAC220008, 0, 2, 1'b0, 4);   // reset during sw MEM
      run_txn(32'h34220FFF, 0, 0, 1'b0, 0);   // ori
      run_txn(32'h3C021234, 0, 0, 1'b0, 0);   // lui
      run_txn(32'h08000010, 0, 0, 1'b0, 0);   // j
      run_txn(32'h00221823, 0, 0, 1'b0, 0);   // subu
      run_txn(32'h00221824, 0, 0, 1'b0, 0);   // and
      run_txn(32'h00221825, 0, 0, 1'b0, 0);   // or
      run_txn(32'h0022182A, 0, 0, 1'b0, 0);   // slt
      run_txn(32'h00221820, 0, 0, 1'b0, 0);   // unsupported funct
      run_txn(32'h8C220004, 0, TMO, 1'b0, 0); // DM timeout
      run_txn(32'hAC220008, 0, TMO-1, 1'b0, 0);

      for (int n = 0; n < 200; n++) begin
         run_txn(rand_ins(), rand_delay(), rand_delay(), 1'($urandom),
                 ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 6)) : 0);
      end

      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         r = q.pop_front();
         rst = r.rst; imRdy = r.im_rdy; dmRdy = r.dm_rdy; zero = r.zero; ins = r.ins;
         cur = r;
         cur_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      cur_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
